// File: rtl/sentinel_auth_sequencer_pkg.sv
// Shared types and constants for the Sentinel Lock authorization path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sentinel_pkg;

    // Encoding doubles as the externally visible state_code
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } sentinel_state_t;

    localparam logic [7:0] SENTINEL_KEY = 8'hB6;

    // 7-segment glyphs used by the downstream display logic
    localparam logic [7:0] SegLocked   = 8'hC7;
    localparam logic [7:0] SegVerified = 8'hC1;
    localparam logic [7:0] SegOff      = 8'hFF;

endpackage

// File: rtl/sentinel_down_timer.sv
// Loadable saturating down-counter shared by the session and lockout phases.
// Latency: load/decrement take effect at the next clock edge; zero is combinational from the count.
// Backpressure: none; en simply pauses the count.
module sentinel_down_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement stops at zero so the count never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sentinel_auth_sequencer.sv
// Key-attempt sequencer: compares attempts to KEY, counts failures, times lockout and unlock sessions.
// Latency: result (attempt_done/attempt_ok/unlocked/lockout) one cycle after the attempt is accepted.
// Backpressure: key_ready is high only in LOCKED with ena high; attempts presented otherwise are dropped.
module sentinel_auth_sequencer
    import sentinel_pkg::*;
#(
    parameter logic [7:0] KEY            = SENTINEL_KEY,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 1024,
    parameter int         SESSION_CYCLES = 4096,
    parameter int         CNT_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic [7:0]                         key_in,
    input  logic                               key_valid,
    output logic                               key_ready,
    input  logic                               relock,
    output logic                               attempt_done,
    output logic                               attempt_ok,
    output logic                               unlocked,
    output logic                               lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [1:0]                         state_code
);

    sentinel_state_t  state;
    logic [7:0]       key_q;
    logic             key_match;
    logic             last_fail;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_en;
    logic             timer_zero;

    assign key_match  = (key_q == KEY);
    assign last_fail  = ((int'(fail_count) + 1) >= MAX_FAILS);
    // Held low while reset is asserted so nothing can be handed over mid-reset
    assign key_ready  = rst_n && ena && (state == ST_LOCKED);
    assign state_code = state;

    // Timer reload on leaving CHECK into a timed phase; count only while a timed phase runs
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = CNT_W'(LOCKOUT_CYCLES - 1);
        timer_en       = 1'b0;
        if (ena && (state == ST_CHECK) && (key_match || last_fail)) begin
            timer_load     = 1'b1;
            timer_load_val = key_match ? CNT_W'(SESSION_CYCLES - 1)
                                       : CNT_W'(LOCKOUT_CYCLES - 1);
        end
        if (ena && ((state == ST_UNLOCKED) || (state == ST_LOCKOUT))) begin
            timer_en = 1'b1;
        end
    end

    sentinel_down_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // Main FSM with registered status outputs; everything freezes while ena is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_LOCKED;
            key_q        <= '0;
            fail_count   <= '0;
            attempt_done <= 1'b0;
            attempt_ok   <= 1'b0;
            unlocked     <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            // attempt_done is a strict one-cycle pulse even if ena drops afterwards
            attempt_done <= 1'b0;
            if (ena) begin
                case (state)
                    ST_LOCKED: begin
                        if (key_valid) begin
                            key_q <= key_in;
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        attempt_done <= 1'b1;
                        if (key_match) begin
                            attempt_ok <= 1'b1;
                            fail_count <= '0;
                            unlocked   <= 1'b1;
                            state      <= ST_UNLOCKED;
                        end else if (last_fail) begin
                            attempt_ok <= 1'b0;
                            fail_count <= '0;
                            lockout    <= 1'b1;
                            state      <= ST_LOCKOUT;
                        end else begin
                            attempt_ok <= 1'b0;
                            fail_count <= fail_count + 1'b1;
                            state      <= ST_LOCKED;
                        end
                    end
                    ST_UNLOCKED: begin
                        // relock and expiry in the same cycle collapse into one exit
                        if (relock || timer_zero) begin
                            unlocked <= 1'b0;
                            state    <= ST_LOCKED;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (timer_zero) begin
                            lockout <= 1'b0;
                            state   <= ST_LOCKED;
                        end
                    end
                    default: state <= ST_LOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sentinel_auth_sequencer.sv
// Randomized and directed bench for sentinel_auth_sequencer with a queue-based scoreboard.
// Latency: expects results one cycle after acceptance.
// Backpressure: waits on key_ready before presenting each attempt.
module tb_sentinel_auth_sequencer;

    localparam logic [7:0] KEY_VAL = 8'hB6;
    localparam int MAXF = 3;
    localparam int LOCK_C = 1024;
    localparam int SESS_C = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] key_in = '0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       relock = 1'b0;
    logic       attempt_done;
    logic       attempt_ok;
    logic       unlocked;
    logic       lockout;
    logic [1:0] fail_count;
    logic [1:0] state_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checking = 1'b0;
    int m_fails = 0;

    typedef struct {
        bit ok;
        bit lk;
        int fails;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sentinel_auth_sequencer #(
        .KEY            (KEY_VAL),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCK_C),
        .SESSION_CYCLES (SESS_C),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .relock       (relock),
        .attempt_done (attempt_done),
        .attempt_ok   (attempt_ok),
        .unlocked     (unlocked),
        .lockout      (lockout),
        .fail_count   (fail_count),
        .state_code   (state_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: status-flag consistency every cycle, scoreboard pop on every result pulse
    always @(negedge clk) begin
        if (checking) begin
            check("ready_rule", int'(key_ready), int'(rst_n && ena && state_code == 2'd0));
            check("flag_rule", {unlocked, lockout}, {state_code == 2'd2, state_code == 2'd3});
            if (attempt_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("attempt_ok", int'(attempt_ok), int'(mon_e.ok));
                    check("fail_count", int'(fail_count), mon_e.fails);
                    check("unlocked_at_done", int'(unlocked), int'(mon_e.ok));
                    check("lockout_at_done", int'(lockout), int'(mon_e.lk));
                    check("done_latency", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Reference: a right key clears the failure tally; the MAXF-th consecutive wrong key locks out
    task automatic attempt(input logic [7:0] k);
        exp_t e;
        int w = 0;
        while (!key_ready && w < 6000) begin
            w++;
            tick();
        end
        if (!key_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        key_in = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        e.ok = (k == KEY_VAL);
        e.lk = 1'b0;
        if (e.ok) begin
            m_fails = 0;
        end else if (m_fails + 1 >= MAXF) begin
            m_fails = 0;
            e.lk = 1'b1;
        end else begin
            m_fails = m_fails + 1;
        end
        e.fails = m_fails;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Counts cycles unlocked stays high; raises relock when the count reaches relock_at
    task automatic run_unlocked(input int relock_at, output int n);
        n = 0;
        while (unlocked && n < SESS_C + 20) begin
            n++;
            relock = (n == relock_at);
            tick();
        end
        relock = 1'b0;
    endtask

    // Counts lockout cycles while poking ignored attempts/relocks and optionally dropping ena
    task automatic run_lockout(input bit drop_ena, output int n_en, output int n_tot);
        n_en = 0;
        n_tot = 0;
        while (lockout && n_tot < LOCK_C + 800) begin
            ena = !(drop_ena && n_tot >= 200 && n_tot < 700);
            key_in = KEY_VAL;
            key_valid = (n_tot % 50 == 0);
            relock = (n_tot % 37 == 0);
            if (ena) n_en++;
            n_tot++;
            tick();
        end
        ena = 1'b1;
        key_valid = 1'b0;
        relock = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_state", int'(state_code), 0);
        check("rst_fail_count", int'(fail_count), 0);
        check("rst_outputs", {attempt_done, attempt_ok, unlocked, lockout}, 0);
        check("rst_ready", int'(key_ready), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n, n2, ra;
        logic [7:0] k;

        // Reset
        rst_n = 1'b0;
        tick(); tick();
        checking = 1'b1;
        check_reset_state();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", int'(key_ready), 1);

        // Correct key, full-length session
        attempt(KEY_VAL);
        tick();
        run_unlocked(-1, n);
        check("session_len", n, SESS_C);
        check("ready_after_session", int'(key_ready), 1);

        // Two failures then success, early relock
        attempt(8'h00);
        attempt(8'h11);
        attempt(KEY_VAL);
        tick();
        run_unlocked(100, n);
        check("relock_len", n, 100);
        check("ready_after_relock", int'(key_ready), 1);

        // Three failures -> lockout, ignored attempts and relock
        attempt(8'h01); attempt(8'h02); attempt(8'h03);
        tick();
        run_lockout(1'b0, n, n2);
        check("lockout_len", n, LOCK_C);

        // Lockout with a 500-cycle ena drop
        attempt(8'h04); attempt(8'h05); attempt(8'h06);
        tick();
        run_lockout(1'b1, n, n2);
        check("lockout_len_ena", n, LOCK_C);
        check("lockout_total_ena", n2, LOCK_C + 500);

        // Relock coinciding with expiry
        attempt(KEY_VAL);
        tick();
        run_unlocked(SESS_C, n);
        check("relock_at_zero_len", n, SESS_C);
        check("relock_at_zero_state", int'(state_code), 0);
        repeat (5) tick();
        check("relock_at_zero_ready", int'(key_ready), 1);

        // Reset mid-lockout
        attempt(8'h07); attempt(8'h08); attempt(8'h09);
        tick();
        repeat (50) tick();
        check("in_lockout", int'(lockout), 1);
        rst_n = 1'b0;
        sb.delete();
        m_fails = 0;
        tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();

        // Reset mid-check
        attempt(8'h0A);
        attempt(8'h0B);
        check("in_check", int'(state_code), 1);
        rst_n = 1'b0;
        sb.delete();
        m_fails = 0;
        tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();
        attempt(8'h0C);
        tick(); tick();
        check("fails_after_reset", int'(fail_count), 1);

        // Randomized attempts
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                ena = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                ena = 1'b1;
            end
            if ($urandom_range(0, 9) < 3) k = KEY_VAL;
            else k = 8'($urandom_range(0, 255));
            attempt(k);
            tick();
            if (unlocked) begin
                ra = int'($urandom_range(1, 30));
                run_unlocked(ra, n);
                check("rand_session", n, ra);
            end else if (lockout) begin
                run_lockout(1'b0, n, n2);
                check("rand_lockout", n, LOCK_C);
            end
        end

        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sentinel_auth_sequencer.md
# sentinel_auth_sequencer

Sequencing controller for the Sentinel Lock authorization path. It accepts 8-bit key attempts through a valid/ready handshake and compares each one against the authorization key. It counts consecutive failures and enforces a timed lockout after too many failures. After a successful attempt it holds an unlock session that ends on timeout or on an explicit relock. It sits between the DIP-switch key port and the 7-segment/status-array output logic, and drives their `unlocked`/`lockout` indications.

## Interface
- `KEY`, 8'hB6, authorization key value
- `MAX_FAILS`, 3, consecutive failed attempts that trigger lockout; must be ≥1
- `LOCKOUT_CYCLES`, 1024, clock cycles spent in LOCKOUT; must be ≥1
- `SESSION_CYCLES`, 4096, clock cycles an unlock session lasts; must be ≥1
- `CNT_W`, 16, timer width; must hold max(LOCKOUT_CYCLES, SESSION_CYCLES)−1
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  reset; synchronous, active-low
- `ena`  in  1  power-state enable; when low the block freezes
- `key_in`  in  8  key attempt value
- `key_valid`  in  1  an attempt is presented
- `key_ready`  out  1  the block can accept an attempt
- `relock`  in  1  request to end the unlock session
- `attempt_done`  out  1  one-cycle pulse when an attempt is resolved
- `attempt_ok`  out  1  result of the attempt; valid only with `attempt_done`
- `unlocked`  out  1  high in UNLOCKED
- `lockout`  out  1  high in LOCKOUT
- `fail_count`  out  $clog2(MAX_FAILS+1)  current count of consecutive failures
- `state_code`  out  2  encoded state: 0 LOCKED, 1 CHECK, 2 UNLOCKED, 3 LOCKOUT

## Operation
- States: LOCKED, CHECK, UNLOCKED, LOCKOUT.
- Reset values:
  - state = LOCKED; key register = 0; timer = 0; fail_count = 0.
  - `attempt_done` = 0, `attempt_ok` = 0, `unlocked` = 0, `lockout` = 0.
  - `key_ready` = 0 during reset; it rises in the first cycle after reset only if `ena` = 1.
- `key_ready` = (state == LOCKED) & `ena`. It is combinational from registered state and `ena`.
- LOCKED:
  - When `key_valid` & `key_ready` are both high at a clock edge, capture `key_in` and go to CHECK.
  - If `key_valid` is high while `key_ready` is low, the attempt is ignored. Nothing is captured or counted.
- CHECK (exactly one cycle):
  - Captured key == KEY:
    - Go to UNLOCKED, load timer = SESSION_CYCLES−1, clear fail_count.
    - Pulse `attempt_done` with `attempt_ok` = 1.
  - Mismatch with fail_count+1 < MAX_FAILS:
    - Increment fail_count and return to LOCKED.
    - Pulse `attempt_done` with `attempt_ok` = 0.
  - Mismatch with fail_count+1 == MAX_FAILS:
    - Go to LOCKOUT, load timer = LOCKOUT_CYCLES−1, clear fail_count.
    - Pulse `attempt_done` with `attempt_ok` = 0.
- UNLOCKED:
  - The timer decrements each cycle.
  - When `relock` = 1 or timer == 0, go to LOCKED.
  - If both occur in the same cycle, there is a single transition to LOCKED.
- LOCKOUT:
  - The timer decrements each cycle; at timer == 0, go to LOCKED.
  - `relock` is ignored.
  - `key_valid` is ignored; `key_ready` stays 0.
- `ena` = 0:
  - State, timer and fail_count hold their values and `key_ready` = 0.
  - Toggling `ena` must never shorten a lockout or extend a session.
- Asserting reset mid-operation returns to LOCKED with fail_count = 0. This applies in any state, including LOCKOUT.
- The timer never wraps. A decrement is applied only while timer > 0.

## Timing
- Attempt accepted at edge N → CHECK during cycle N..N+1 → `attempt_done`, `attempt_ok`, `unlocked` and `lockout` all update at edge N+1. Attempt-to-result latency is 1 cycle after acceptance.
- All outputs except `key_ready` are registered.
- `unlocked` stays high for exactly SESSION_CYCLES cycles when there is no `relock` and `ena` stays 1.
- `lockout` stays high for exactly LOCKOUT_CYCLES cycles with `ena` = 1.
- `relock` sampled at edge M → `unlocked` falls at edge M, and `key_ready` is high in the following cycle.
- Back-to-back attempts are possible at most every 2 cycles: accept, CHECK, accept.

## Structure
- Shared package `sentinel_pkg`:
  - state enum `sentinel_state_t`, with values matching `state_code`;
  - default key constant `SENTINEL_KEY` = 8'hB6;
  - 7-segment constants `SegLocked` = 8'hC7, `SegVerified` = 8'hC1, `SegOff` = 8'hFF.
- Sub-module `sentinel_down_timer`:
  - Loadable down-counter of CNT_W bits, with `load`, `load_val`, `en` (decrement) and a `zero` flag.
  - It is shared by the session and lockout phases; only one phase is active at a time.

## Test plan
- Reset, then present `key_in` = 8'hB6 with `key_valid` → `attempt_done` = 1 and `attempt_ok` = 1 one cycle after acceptance. `unlocked` = 1 for exactly 4096 cycles, then LOCKED with `key_ready` = 1.
- Present 8'h00, then 8'h11 → two `attempt_done` pulses with `attempt_ok` = 0 and fail_count = 1, then 2. Then present 8'hB6 → unlock, and fail_count = 0.
- Present three wrong keys → `lockout` = 1 for exactly 1024 cycles and `key_ready` = 0 throughout. During lockout, present 8'hB6 and assert `relock` → both ignored.
- During a lockout, drop `ena` for 500 cycles → timer frozen. Total `lockout`-high cycles counted with `ena` = 1 still equals 1024.
- Unlock, then assert `relock` on the same cycle the timer reaches 0 → single return to LOCKED with no glitch and no extra `attempt_done`.
- Assert `rst_n` = 0 mid-LOCKOUT and mid-CHECK → next cycle state_code = 0, fail_count = 0, all registered outputs 0.
